// File: rtl/llc_bus_agent_pkg.sv
// Shared LLC bus types: bus operation and snoop result encodings,
// plus the snoop priority helpers used by the bus agent and merge tree.
package cache_define;

  typedef enum logic [2:0] {
    BUS_NONE       = 3'd0,
    BUS_READ       = 3'd1,
    BUS_WRITE      = 3'd2,
    BUS_INVALIDATE = 3'd3,
    BUS_RWIM       = 3'd4
  } bus_op_t;

  typedef enum logic [1:0] {
    NOHIT = 2'd0,
    HIT   = 2'd1,
    HITM  = 2'd2
  } snoop_t;

  // Code 3 is not a legal result; fold it to NOHIT on capture.
  function automatic logic [1:0] snoop_clean(logic [1:0] s);
    return (s == 2'd3) ? 2'd0 : s;
  endfunction

  // HITM beats HIT beats NOHIT.
  function automatic logic [1:0] snoop_merge2(logic [1:0] a,
                                             logic [1:0] b);
    if (a == HITM || b == HITM) return HITM;
    if (a == HIT || b == HIT) return HIT;
    return NOHIT;
  endfunction

endpackage

// File: rtl/llc_bus_agent_merge.sv
// llc_snoop_merge: combinational reduction of per-channel snoop results.
// Ports: vec (2 bits per channel) in; result, hitm_id (lowest HITM) out.
module llc_snoop_merge
  import cache_define::*;
#(
  parameter int NUM_SNOOPERS = 3
) (
  input  logic [2*NUM_SNOOPERS-1:0]         vec,
  output logic [1:0]                        result,
  output logic [$clog2(NUM_SNOOPERS)-1:0]   hitm_id
);

  localparam int IW = $clog2(NUM_SNOOPERS);

  // Walk high to low so the lowest HITM index is the last one written.
  always_comb begin
    result  = NOHIT;
    hitm_id = '0;
    for (int i = NUM_SNOOPERS - 1; i >= 0; i--) begin
      result = snoop_merge2(result, vec[2*i +: 2]);
      if (vec[2*i +: 2] == HITM) hitm_id = IW'(i);
    end
  end

endmodule

// File: rtl/llc_bus_agent.sv
// llc_bus_agent: broadcasts one LLC bus op to peer snoopers, collects
// and merges their results. Ports: req_* (op in), bus_* (broadcast),
// snoop_* (per-channel results), resp_* (merged result out).
// Optional macro SNOOP_TIMEOUT_EN enables the snoop wait deadline.
module llc_bus_agent
  import cache_define::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_SNOOPERS  = 3,
  parameter int SNOOP_TIMEOUT = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [2:0]                      req_op,
  input  logic [ADDRESS_WIDTH-1:0]        req_addr,
  output logic                            bus_op_valid,
  output logic [2:0]                      bus_op,
  output logic [ADDRESS_WIDTH-1:0]        bus_addr,
  input  logic [NUM_SNOOPERS-1:0]         snoop_valid,
  input  logic [2*NUM_SNOOPERS-1:0]       snoop_result,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [1:0]                      resp_result,
  output logic [2*NUM_SNOOPERS-1:0]       resp_vec,
  output logic [$clog2(NUM_SNOOPERS)-1:0] resp_hitm_id,
  output logic                            resp_timeout
);

  localparam int IW = $clog2(NUM_SNOOPERS);
  localparam int SW = 2 * NUM_SNOOPERS;

  typedef enum logic [1:0] {
    IDLE,
    BCAST,
    COLLECT,
    DONE
  } state_t;

  state_t                   state, state_nxt;
  logic [NUM_SNOOPERS-1:0]  got, got_nxt;
  logic [SW-1:0]            vec, vec_nxt;
  logic [2:0]               op_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [1:0]               res_q;
  logic [IW-1:0]            id_q;
  logic                     to_q;
  logic                     accept;
  logic                     cap_en;
  logic                     all_got;
  logic                     expire;
  logic                     enter_done;
  logic [1:0]               mrg_result;
  logic [IW-1:0]            mrg_id;

  assign accept = req_valid && (state == IDLE);
  // WRITE never collects, so its BCAST cycle does not sample strobes.
  assign cap_en = (state == BCAST && op_q != BUS_WRITE) ||
                  (state == COLLECT);

  // First strobe per channel wins; later strobes are dropped.
  always_comb begin
    got_nxt = got;
    vec_nxt = vec;
    if (accept) begin
      got_nxt = '0;
      vec_nxt = '0;
    end else if (cap_en) begin
      for (int i = 0; i < NUM_SNOOPERS; i++) begin
        if (snoop_valid[i] && !got[i]) begin
          got_nxt[i]       = 1'b1;
          vec_nxt[2*i +: 2] = snoop_clean(snoop_result[2*i +: 2]);
        end
      end
    end
  end

  // Includes responses arriving this cycle.
  assign all_got = &got_nxt;

`ifdef SNOOP_TIMEOUT_EN
  localparam int CW = $clog2(SNOOP_TIMEOUT + 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (cap_en && !all_got) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A response landing in the expiry cycle makes all_got true
  // and so counts as on time.
  assign expire = cap_en && !all_got &&
                  (cnt == CW'(SNOOP_TIMEOUT));
`else
  logic unused_cfg;
  assign unused_cfg = (SNOOP_TIMEOUT != 0);
  assign expire     = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    bus_op_valid = 1'b0;
    resp_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = BCAST;
      end
      BCAST: begin
        bus_op_valid = 1'b1;
        if (op_q == BUS_WRITE || all_got || expire)
          state_nxt = DONE;
        else
          state_nxt = COLLECT;
      end
      COLLECT: begin
        if (all_got || expire) state_nxt = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_done = (state != DONE) && (state_nxt == DONE);

  llc_snoop_merge #(
    .NUM_SNOOPERS(NUM_SNOOPERS)
  ) u_merge (
    .vec     (vec_nxt),
    .result  (mrg_result),
    .hitm_id (mrg_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      got    <= '0;
      vec    <= '0;
      op_q   <= '0;
      addr_q <= '0;
      res_q  <= '0;
      id_q   <= '0;
      to_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      got   <= got_nxt;
      vec   <= vec_nxt;
      if (accept) begin
        op_q   <= req_op;
        addr_q <= req_addr;
        res_q  <= '0;
        id_q   <= '0;
        to_q   <= 1'b0;
      end else if (enter_done) begin
        res_q <= mrg_result;
        id_q  <= mrg_id;
        to_q  <= expire;
      end
    end
  end

  assign bus_op       = op_q;
  assign bus_addr     = addr_q;
  assign resp_result  = res_q;
  assign resp_vec     = vec;
  assign resp_hitm_id = id_q;
  assign resp_timeout = to_q;

endmodule

// File: tb/tb_llc_bus_agent.sv
// Scoreboard bench for llc_bus_agent: stimulus pushes expected
// responses, a negedge monitor pops and compares them.
module tb_llc_bus_agent;
  import cache_define::*;

  localparam int AW = 32;
  localparam int NS = 3;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [AW-1:0] req_addr;
  logic          bus_op_valid;
  logic [2:0]    bus_op;
  logic [AW-1:0] bus_addr;
  logic [NS-1:0] snoop_valid;
  logic [5:0]    snoop_result;
  logic          resp_valid;
  logic          resp_ready;
  logic [1:0]    resp_result;
  logic [5:0]    resp_vec;
  logic [1:0]    resp_hitm_id;
  logic          resp_timeout;

  always #5 clk = ~clk;

  llc_bus_agent #(
    .ADDRESS_WIDTH(AW),
    .NUM_SNOOPERS (NS),
    .SNOOP_TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .bus_op_valid(bus_op_valid),
    .bus_op      (bus_op),
    .bus_addr    (bus_addr),
    .snoop_valid (snoop_valid),
    .snoop_result(snoop_result),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_vec    (resp_vec),
    .resp_hitm_id(resp_hitm_id),
    .resp_timeout(resp_timeout)
  );

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] addr;
    logic [1:0]    res;
    logic [5:0]    vec;
    logic [1:0]    id;
    logic          to;
    int            lat;
    int            gap;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   hs_cyc   = 0;
  bit   in_resp  = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic [2:0] op, logic [AW-1:0] addr,
                              logic [1:0] res, logic [5:0] vec,
                              logic [1:0] id, logic to,
                              int lat, int gap);
    exp_t e;
    e.op = op; e.addr = addr; e.res = res; e.vec = vec;
    e.id = id; e.to = to; e.lat = lat; e.gap = gap;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      in_resp = 0;
    end else begin
      if (req_valid && req_ready) begin
        if (q.size() > 0 && q[0].gap > 0)
          chk("b2b_gap", cyc - hs_cyc, q[0].gap);
        acc_cyc = cyc;
      end
      if (bus_op_valid) begin
        if (q.size() == 0) chk("bcast_unexpected", q.size(), 1);
        else begin
          chk("bcast_cycle", cyc - acc_cyc, 1);
          chk("bus_op", bus_op, q[0].op);
          chk("bus_addr", bus_addr, q[0].addr);
        end
      end
      if (resp_valid) begin
        if (q.size() == 0) chk("resp_unexpected", q.size(), 1);
        else begin
          if (!in_resp) begin
            chk("resp_latency", cyc - acc_cyc, q[0].lat);
            in_resp = 1;
          end
          chk("resp_result", resp_result, q[0].res);
          chk("resp_vec", resp_vec, q[0].vec);
          chk("resp_hitm_id", resp_hitm_id, q[0].id);
          chk("resp_timeout", resp_timeout, q[0].to);
          chk("req_ready_in_done", req_ready, 0);
          if (resp_ready) begin
            void'(q.pop_front());
            in_resp = 0;
            hs_cyc  = cyc;
          end
        end
      end
    end
  end

  task automatic chk_reset(string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_bus_op_valid"}, bus_op_valid, 0);
    chk({tag, "_bus_op"}, bus_op, 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_result"}, resp_result, 0);
    chk({tag, "_resp_vec"}, resp_vec, 0);
    chk({tag, "_resp_hitm_id"}, resp_hitm_id, 0);
    chk({tag, "_resp_timeout"}, resp_timeout, 0);
  endtask

  // Returns one tick after the accepting edge (the BCAST cycle).
  task automatic wait_accept();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 60) begin
        chk("accept_wait_expired", n, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(exp_t e);
    q.push_back(e);
    req_op    = e.op;
    req_addr  = e.addr;
    req_valid = 1'b1;
    wait_accept();
    req_valid = 1'b0;
  endtask

  task automatic drive_snoop(logic [2:0] v, logic [5:0] r);
    snoop_valid  = v;
    snoop_result = r;
    @(posedge clk);
    #1;
    snoop_valid  = '0;
    snoop_result = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready && !resp_valid) break;
      n++;
      if (n > 60) begin
        chk("idle_wait_expired", n, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (resp_valid) break;
      n++;
      if (n > 60) begin
        chk("resp_wait_expired", n, 0);
        break;
      end
    end
  endtask

  initial begin
    req_valid    = 1'b0;
    req_op       = '0;
    req_addr     = '0;
    snoop_valid  = '0;
    snoop_result = '0;
    resp_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("por");
    @(posedge clk);
    #1;

    // Reset while collecting.
    issue(mk(BUS_READ, 32'h0000_0f00, 2'd0, 6'h00, 2'd0, 1'b0, 2, 0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_reset("mid");
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 1);
    @(posedge clk);
    #1;

    // READ: ch0 HIT, ch1 NOHIT, ch2 HITM.
    issue(mk(BUS_READ, 32'h0000_1000, 2'd2, 6'h21, 2'd2, 1'b0, 2, 0));
    drive_snoop(3'b111, 6'b10_00_01);
    wait_idle();

    // WRITE: strobes in BCAST and DONE are ignored.
    issue(mk(BUS_WRITE, 32'h0000_2040, 2'd0, 6'h00, 2'd0, 1'b0, 2, 0));
    drive_snoop(3'b111, 6'b10_10_10);
    drive_snoop(3'b111, 6'b10_10_10);
    wait_idle();

`ifdef SNOOP_TIMEOUT_EN
    // RWIM, ch1 silent: deadline expires.
    issue(mk(BUS_RWIM, 32'h0000_3000, 2'd1, 6'h01, 2'd0, 1'b1, 17, 0));
    drive_snoop(3'b101, 6'b00_00_01);
    wait_idle();
    // RWIM, ch1 answers (code 3) in the expiry cycle: on time.
    issue(mk(BUS_RWIM, 32'h0000_3080, 2'd1, 6'h01, 2'd0, 1'b0, 17, 0));
    drive_snoop(3'b101, 6'b00_00_01);
    repeat (14) @(posedge clk);
    #1;
    drive_snoop(3'b010, 6'b00_11_00);
    wait_idle();
`else
    // RWIM, ch1 late HITM: no response until it arrives.
    issue(mk(BUS_RWIM, 32'h0000_3000, 2'd2, 6'h09, 2'd1, 1'b0, 26, 0));
    drive_snoop(3'b101, 6'b00_00_01);
    repeat (23) @(posedge clk);
    #1;
    drive_snoop(3'b010, 6'b00_10_00);
    wait_idle();
`endif

    // INVALIDATE: ch0 HIT then HITM, ch2 code 3, slow consumer.
    resp_ready = 1'b0;
    issue(mk(BUS_INVALIDATE, 32'h0000_4000, 2'd1, 6'h01, 2'd0, 1'b0, 3, 0));
    drive_snoop(3'b001, 6'b00_00_01);
    drive_snoop(3'b111, 6'b11_00_10);
    wait_resp();
    @(posedge clk);
    #1;
    drive_snoop(3'b010, 6'b00_10_00);
    repeat (3) @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_idle();

    // Back-to-back READs with req_valid held high.
    q.push_back(mk(BUS_READ, 32'h0000_5000, 2'd0, 6'h00, 2'd0, 1'b0, 2, 0));
    q.push_back(mk(BUS_READ, 32'h0000_5040, 2'd2, 6'h29, 2'd1, 1'b0, 2, 1));
    req_op    = BUS_READ;
    req_addr  = 32'h0000_5000;
    req_valid = 1'b1;
    wait_accept();
    req_addr = 32'h0000_5040;
    drive_snoop(3'b111, 6'b00_00_00);
    wait_accept();
    req_valid = 1'b0;
    drive_snoop(3'b111, 6'b10_10_01);
    wait_idle();

    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
